// File: rtl/spi_xform_pkg.sv
// Shared types for the SPI transforming slave: transform selector and FSM states.
package spi_xform_pkg;

  // Transform applied to a received frame before it is shifted back out.
  typedef enum logic [1:0] {
    OP_REV    = 2'd0,
    OP_ECHO   = 2'd1,
    OP_INV    = 2'd2,
    OP_REVINV = 2'd3
  } op_e;

  // Frame-level controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    TX   = 2'd2
  } state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous input. While reset is asserted
// both stages hold RST_VAL, so the synchronized output shows the line's idle
// level and no spurious edge is produced when reset is released.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Shift the asynchronous level through two flops to settle metastability.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_reg <= RST_VAL;
      sync_reg <= RST_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/spi_xform_slave.sv
// SPI slave (CPHA=0) that receives a WIDTH-bit frame LSB-first-by-arrival,
// reports it on rx_data/rx_valid, then returns a transformed copy on miso
// during the following WIDTH sck cycles. Frames repeat while ss stays low.
module spi_xform_slave
  import spi_xform_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CPOL  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sck,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic           SCK_IDLE = (CPOL != 0);

  logic ss_sync;
  logic sck_sync;
  logic mosi_sync;

  spi_sync #(.RST_VAL(1'b1)) u_ss_sync (
    .clock (clock),
    .reset (reset),
    .d     (ss),
    .q     (ss_sync)
  );

  spi_sync #(.RST_VAL(SCK_IDLE)) u_sck_sync (
    .clock (clock),
    .reset (reset),
    .d     (sck),
    .q     (sck_sync)
  );

  spi_sync #(.RST_VAL(1'b0)) u_mosi_sync (
    .clock (clock),
    .reset (reset),
    .d     (mosi),
    .q     (mosi_sync)
  );

  // After inversion the controller always sees an idle-low sck.
  logic sck_norm;
  logic sck_prev_reg;
  logic sck_rise;
  logic sck_fall;

  assign sck_norm = sck_sync ^ SCK_IDLE;
  assign sck_rise = sck_norm & ~sck_prev_reg;
  assign sck_fall = ~sck_norm & sck_prev_reg;

  // Third copy of normalized sck used as the edge-detect reference.
  always_ff @(posedge clock) begin
    if (reset) sck_prev_reg <= 1'b0;
    else       sck_prev_reg <= sck_norm;
  end

  state_e           state_reg;
  op_e              op_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] t_reg;
  logic [WIDTH-1:0] rx_data_reg;
  logic             rx_valid_reg;
  logic             miso_reg;

  // Shift register contents including the bit arriving on this rising edge,
  // so the final bit of a frame can be reported and transformed immediately.
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] r_rev;
  logic [WIDTH-1:0] t_next;

  // Insert the current mosi sample at the bit position given by the counter.
  always_comb begin
    r_next          = r_reg;
    r_next[cnt_reg] = mosi_sync;
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign r_rev[gi] = r_next[WIDTH-1-gi];
  end

  // Select the transform latched at the start of this frame.
  always_comb begin
    case (op_reg)
      OP_REV:  t_next = r_rev;
      OP_ECHO: t_next = r_next;
      OP_INV:  t_next = ~r_next;
      default: t_next = ~r_rev;
    endcase
  end

  // Frame controller: receive WIDTH bits, publish, then shift out the transform.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      op_reg       <= OP_REV;
      cnt_reg      <= '0;
      r_reg        <= '0;
      t_reg        <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      miso_reg     <= 1'b1;
    end else begin
      rx_valid_reg <= 1'b0;
      if (ss_sync) begin
        // Deselect aborts any frame in progress; rx_data is kept.
        state_reg <= IDLE;
        cnt_reg   <= '0;
        miso_reg  <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= RX;
            cnt_reg   <= '0;
            op_reg    <= op_e'(op);
            miso_reg  <= 1'b1;
          end
          RX: begin
            if (sck_rise) begin
              r_reg <= r_next;
              if (cnt_reg == LAST) begin
                state_reg    <= TX;
                cnt_reg      <= '0;
                rx_data_reg  <= r_next;
                rx_valid_reg <= 1'b1;
                t_reg        <= t_next;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end
          end
          TX: begin
            if (sck_rise) begin
              if (cnt_reg == LAST) begin
                state_reg <= RX;
                cnt_reg   <= '0;
                op_reg    <= op_e'(op);
                miso_reg  <= 1'b1;
              end else begin
                cnt_reg <= cnt_reg + 1'b1;
              end
            end else if (sck_fall) begin
              miso_reg <= t_reg[cnt_reg];
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign miso     = miso_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_xform_slave.sv
// Scoreboard bench for spi_xform_slave. Two instances (CPOL=0 and CPOL=1)
// share one SPI master; expected frames and miso bits are queued by the
// stimulus and consumed by independent monitors.
module tb_spi_xform_slave;

  localparam int HALF = 8;  // clock cycles per sck half-period

  logic       clock = 1'b0;
  logic       reset;
  logic       sck_lvl;
  logic       sck_inv;
  logic       ss;
  logic       mosi;
  logic [1:0] op;

  logic       miso0, miso1;
  logic       rx_valid0, rx_valid1;
  logic [7:0] rx_data0, rx_data1;

  logic [7:0] exp_rx0[$];
  logic [7:0] exp_rx1[$];
  logic       exp_miso[$];
  logic       tx_window;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  assign sck_inv = ~sck_lvl;

  spi_xform_slave #(.WIDTH(8), .CPOL(0)) dut0 (
    .clock    (clock),
    .reset    (reset),
    .sck      (sck_lvl),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso0),
    .op       (op),
    .rx_data  (rx_data0),
    .rx_valid (rx_valid0)
  );

  spi_xform_slave #(.WIDTH(8), .CPOL(1)) dut1 (
    .clock    (clock),
    .reset    (reset),
    .sck      (sck_inv),
    .ss       (ss),
    .mosi     (mosi),
    .miso     (miso1),
    .op       (op),
    .rx_data  (rx_data1),
    .rx_valid (rx_valid1)
  );

  // Reference transform: bit i of the result is what the master sees i-th.
  function automatic logic [7:0] xform(input logic [1:0] o, input logic [7:0] r);
    logic [7:0] rev;
    rev = {<<{r}};
    case (o)
      2'd0:    return rev;
      2'd1:    return r;
      2'd2:    return ~r;
      default: return ~rev;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic push_frame(input logic [7:0] data, input logic [1:0] o, input int ntx);
    logic [7:0] t;
    exp_rx0.push_back(data);
    exp_rx1.push_back(data);
    t = xform(o, data);
    for (int i = 0; i < ntx; i++) exp_miso.push_back(t[i]);
  endtask

  task automatic rx_bits(input logic [7:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = data[i];
      clk_wait(HALF);
      sck_lvl = 1'b1;
      clk_wait(HALF);
      sck_lvl = 1'b0;
    end
  endtask

  task automatic tx_bits(input int n);
    tx_window = 1'b1;
    for (int i = 0; i < n; i++) begin
      mosi = 1'($urandom_range(1));
      clk_wait(HALF);
      sck_lvl = 1'b1;
      clk_wait(HALF);
      sck_lvl = 1'b0;
    end
    tx_window = 1'b0;
  endtask

  task automatic frame(input logic [7:0] data, input logic [1:0] o_used, input logic [1:0] o_next);
    push_frame(data, o_used, 8);
    rx_bits(data, 8);
    op = o_next;
    tx_bits(8);
  endtask

  task automatic ss_low(input logic [1:0] o);
    op = o;
    ss = 1'b0;
  endtask

  task automatic ss_high();
    clk_wait(HALF);
    ss = 1'b1;
    clk_wait(2 * HALF);
  endtask

  // Receive-side monitor for the CPOL=0 instance.
  always @(negedge clock) begin
    if (rx_valid0) begin
      if (exp_rx0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx0_unexpected: got rx_valid with data %02h expected no frame", rx_data0);
      end else begin
        logic [7:0] e;
        e = exp_rx0.pop_front();
        check("rx_data0", rx_data0, e);
        $display("dut0 rx frame %02h (expected %02h)", rx_data0, e);
      end
    end
  end

  // Receive-side monitor for the CPOL=1 instance.
  always @(negedge clock) begin
    if (rx_valid1) begin
      if (exp_rx1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx1_unexpected: got rx_valid with data %02h expected no frame", rx_data1);
      end else begin
        logic [7:0] e;
        e = exp_rx1.pop_front();
        check("rx_data1", rx_data1, e);
        $display("dut1 rx frame %02h (expected %02h)", rx_data1, e);
      end
    end
  end

  // Transmit-side monitor: the master samples miso on each rising sck in TX.
  always @(posedge sck_lvl) begin
    if (tx_window) begin
      if (exp_miso.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL miso_unexpected: got sample %b/%b expected none", miso0, miso1);
      end else begin
        logic b;
        b = exp_miso.pop_front();
        check("miso0", miso0, b);
        check("miso1", miso1, b);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t;
    logic [1:0] o, on;
    int         n;

    reset     = 1'b1;
    ss        = 1'b1;
    sck_lvl   = 1'b0;
    mosi      = 1'b0;
    op        = 2'd0;
    tx_window = 1'b0;

    // Reset state
    clk_wait(3);
    check("reset_miso0", miso0, 1'b1);
    check("reset_miso1", miso1, 1'b1);
    check("reset_rx_data0", rx_data0, 8'h00);
    check("reset_rx_data1", rx_data1, 8'h00);
    check("reset_rx_valid0", rx_valid0, 1'b0);
    check("reset_rx_valid1", rx_valid1, 1'b0);
    reset = 1'b0;
    clk_wait(4);

    // Reference frame under bit-reverse, echo and invert
    ss_low(2'd0); frame(8'h0D, 2'd0, 2'd0); ss_high();
    ss_low(2'd1); frame(8'h0D, 2'd1, 2'd1); ss_high();
    ss_low(2'd2); frame(8'h0D, 2'd2, 2'd2); ss_high();

    // sck activity while deselected must be ignored
    for (int i = 0; i < 3; i++) begin
      mosi = 1'($urandom_range(1));
      clk_wait(HALF);
      sck_lvl = 1'b1;
      clk_wait(HALF);
      sck_lvl = 1'b0;
    end
    clk_wait(HALF);

    // Back-to-back frames under one select
    ss_low(2'd0); frame(8'h01, 2'd0, 2'd0); frame(8'hF0, 2'd0, 2'd0); ss_high();

    // Abort after three RX bits, then a clean frame
    ss_low(2'd0);
    rx_bits(8'hFF, 3);
    ss = 1'b1;
    clk_wait(4);
    check("abort_rx_miso0", miso0, 1'b1);
    check("abort_rx_miso1", miso1, 1'b1);
    clk_wait(2 * HALF);
    ss_low(2'd0); frame(8'h5A, 2'd0, 2'd0); ss_high();

    // Abort during TX while miso is driving a zero
    ss_low(2'd1);
    push_frame(8'h00, 2'd1, 0);
    rx_bits(8'h00, 8);
    clk_wait(6);
    check("tx_bit0_miso0", miso0, 1'b0);
    check("tx_bit0_miso1", miso1, 1'b0);
    ss = 1'b1;
    clk_wait(4);
    check("abort_tx_miso0", miso0, 1'b1);
    check("abort_tx_miso1", miso1, 1'b1);
    clk_wait(2 * HALF);

    // op changed mid-RX: frame keeps the op latched at RX entry
    ss_low(2'd0);
    push_frame(8'h2B, 2'd0, 8);
    rx_bits(8'h2B, 3);
    op = 2'd1;
    rx_bits(8'h2B >> 3, 5);
    tx_bits(8);
    ss_high();

    // Reset pulsed during TX
    ss_low(2'd0);
    push_frame(8'h0F, 2'd0, 3);
    rx_bits(8'h0F, 8);
    tx_bits(3);
    clk_wait(6);
    t = xform(2'd0, 8'h0F);
    check("pre_reset_miso0", miso0, t[3]);
    check("pre_reset_miso1", miso1, t[3]);
    reset = 1'b1;
    clk_wait(1);
    check("midreset_miso0", miso0, 1'b1);
    check("midreset_miso1", miso1, 1'b1);
    check("midreset_rx_data0", rx_data0, 8'h00);
    check("midreset_rx_data1", rx_data1, 8'h00);
    reset = 1'b0;
    ss = 1'b1;
    clk_wait(2 * HALF);

    // Randomized sessions of one to three back-to-back frames
    for (int s = 0; s < 10; s++) begin
      n = $urandom_range(1, 3);
      o = 2'($urandom_range(3));
      ss_low(o);
      for (int k = 0; k < n; k++) begin
        on = 2'($urandom_range(3));
        frame(8'($urandom_range(255)), o, on);
        o = on;
      end
      ss_high();
    end

    clk_wait(20);
    check("rx0_pending", exp_rx0.size(), 0);
    check("rx1_pending", exp_rx1.size(), 0);
    check("miso_pending", exp_miso.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xform_slave.md
SPI_XFORM_SLAVE -- requirements
Module: spi_xform_slave

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning frame length in bits (legal range 2..32).
REQ-002 SHALL have parameter CPOL, default 0, meaning idle level of sck (1 inverts sck before edge detection); only CPHA=0 timing is supported.
REQ-003 SHALL have port clock  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sck  input  1  SPI clock, asynchronous to clock.
REQ-006 SHALL have port ss  input  1  active-low slave select, asynchronous.
REQ-007 SHALL have port mosi  input  1  master-out data, asynchronous.
REQ-008 SHALL have port miso  output  1  slave-out data, registered.
REQ-009 SHALL have port op  input  2  transform select: 0 bit-reverse, 1 echo, 2 invert, 3 reverse+invert.
REQ-010 SHALL have port rx_data  output  WIDTH  last complete received frame.
REQ-011 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.

Function
REQ-012 SHALL pass sck, ss and mosi through 2-flop synchronizers, then detect edges by comparing against a third registered copy; sck edges are judged after CPOL inversion.
REQ-013 SHALL require the sck period to be at least 10 clock periods; shorter periods are unsupported.
REQ-014 SHALL implement states IDLE, RX, TX.
REQ-015 IDLE -> RX on synchronized ss low. Any state -> IDLE on synchronized ss high.
REQ-016 Entering RX SHALL clear the bit counter, latch op, and set miso=1.
REQ-017 In RX, each rising sck edge SHALL store mosi into r[cnt] (bit i = i-th bit received) and increment cnt.
REQ-018 On the WIDTH-th RX rising edge, the block SHALL:
- go to TX;
- load rx_data with the completed r and pulse rx_valid for exactly one cycle;
- compute t = f(op, r): reverse t[i]=r[WIDTH-1-i]; echo t=r; invert t=~r; reverse+invert t[i]=~r[WIDTH-1-i].
REQ-019 In TX, each falling sck edge SHALL drive miso=t[cnt]; each rising edge SHALL increment cnt. t[0] is driven on the first falling edge after entering TX.
REQ-020 After the WIDTH-th TX rising edge, the block SHALL return to RX per REQ-016, so frames repeat back-to-back while ss stays low.
REQ-021 miso SHALL change within 4 clock cycles of the sck edge that caused it.
REQ-022 ss rising mid-frame SHALL abort: state IDLE, miso=1, counters cleared, no rx_valid pulse, rx_data retained.
REQ-023 A change of op mid-frame SHALL have no effect until the next entry to RX.
REQ-024 In IDLE, sck edges SHALL be ignored.
REQ-025 Counters SHALL be $clog2(WIDTH) bits wide; cnt SHALL never exceed WIDTH-1.

Reset
REQ-026 While reset is high: state=IDLE, miso=1, rx_data=0, rx_valid=0, r=0, t=0, cnt=0, latched op=0.
REQ-027 While reset is high, synchronizer stages SHALL load their idle values (ss=1, sck=CPOL, mosi=0) so that no edge is detected on release.
REQ-028 Reset asserted mid-frame SHALL behave as REQ-026 on the next clock edge.

Structure
REQ-029 Package spi_xform_pkg SHALL hold the op enum (OP_REV, OP_ECHO, OP_INV, OP_REVINV) and the state enum.
REQ-030 Sub-module spi_sync (parametrised 2-flop synchronizer with reset value) SHALL be instantiated once per asynchronous input.

Verification
REQ-031 WIDTH=8, op=0, master sends 1,0,1,1,0,0,0,0 -> rx_data=8'h0D with a single rx_valid pulse; miso returns 0,0,0,0,1,1,0,1.
REQ-032 op=1 with the same frame -> miso 1,0,1,1,0,0,0,0. op=2 -> miso 0,1,0,0,1,1,1,1.
REQ-033 Two back-to-back frames 8'h01 then 8'hF0 under one ss low, op=0 -> two rx_valid pulses, rx_data 8'h01 then 8'hF0; miso carries the reversed bits of each frame in its TX phase.
REQ-034 ss raised after 3 RX bits -> no rx_valid, miso=1 within 4 clocks; the next full frame is received correctly.
REQ-035 op toggled 0->1 during the RX phase -> the TX phase uses bit-reverse.
REQ-036 Reset pulsed during TX -> miso=1, rx_data=0 on the next cycle; CPOL=1 build passes REQ-031.
